// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Clock-divided VGA raster engine with registered, blanking-gated
//            colour, sync, data-enable and line/frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RGB_W    = 8,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [RGB_W-1:0]  pix_rgb_in,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y,
    output logic              pix_tick,
    output logic              hsync,
    output logic              vsync,
    output logic [RGB_W-1:0]  rgb,
    output logic              de,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      c_h_active  = 11'(H_ACTIVE);
    localparam logic [10:0]      c_hs_start  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      c_hs_end    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      c_h_last    = 11'(H_TOTAL - 1);
    localparam logic [9:0]       c_v_active  = 10'(V_ACTIVE);
    localparam logic [9:0]       c_vs_start  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       c_vs_end    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]       c_v_last    = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0]  r_div;
    logic [10:0]       r_h_cnt;
    logic [9:0]        r_v_cnt;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_hsync;
    logic              r_vsync;
    logic [RGB_W-1:0]  r_rgb;
    logic              r_de;
    logic              r_line_start;
    logic              r_frame_start;

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_hs_on;
    logic w_vs_on;
    logic w_de;

    assign w_tick   = en && (r_div == c_div_last);
    assign w_h_last = (r_h_cnt == c_h_last);
    assign w_v_last = (r_v_cnt == c_v_last);
    assign w_hs_on  = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_on  = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign w_de     = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);

    // Outputs describe the coordinate held in the counters at the tick edge,
    // so the pixel source sees pix_x/pix_y a full pixel period before sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_cnt   <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!en) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_div         <= '0;
            r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_rgb         <= w_de ? pix_rgb_in : '0;
            r_line_start  <= (r_h_cnt == 11'd0);
            r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);
            if (w_h_last) begin
                r_h_cnt <= '0;
                if (w_v_last) begin
                    r_v_cnt     <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end else begin
            r_div         <= r_div + 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign pix_x       = r_h_cnt;
    assign pix_y       = r_v_cnt;
    assign pix_tick    = w_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster engine for the Nexys 3 miner display path. It divides the board clock down to a pixel strobe and runs horizontal and vertical counters with configurable porch, sync and active widths, plus selectable sync polarity. It exposes the current pixel coordinate to an upstream pixel source, such as the hash/nonce text renderer. It returns a registered, blanking-gated `rgb`, aligned with `hsync`/`vsync`, along with line-start and frame-start strobes and a frame counter.

## Interface
- `CLK_DIV`, 4: `clk` cycles per pixel, at least 1. 100 MHz / 4 = 25 MHz.
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal widths in pixels.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical widths in lines.
- `HS_POL`, 0 / `VS_POL`, 0: asserted level of the sync pulses (0 = active-low).
- `RGB_W`, 8: colour width. Default is Nexys 3 RRRGGGBB.
- `FCNT_W`, 16: frame counter width.
- `clk`  in  1  board clock. The only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable. Low holds the engine idle.
- `pix_rgb_in`  in  RGB_W  pixel colour for coordinate `pix_x`,`pix_y`.
- `pix_x`  out  11  current horizontal count, `h_cnt`.
- `pix_y`  out  10  current vertical count, `v_cnt`.
- `pix_tick`  out  1  one-clk strobe, the cycle on which `pix_rgb_in` is sampled.
- `hsync`  out  1  horizontal sync, registered.
- `vsync`  out  1  vertical sync, registered.
- `rgb`  out  RGB_W  output colour, zero outside the active area.
- `de`  out  1  data enable, high while `rgb` carries an active pixel.
- `line_start`  out  1  one-clk pulse when the output pixel is at x=0.
- `frame_start`  out  1  one-clk pulse when the output pixel is (0,0).
- `frame_cnt`  out  FCNT_W  completed frames.

## Operation
- Derived totals:
  - `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP. Default 800.
  - `V_TOTAL` = V_ACTIVE+V_FP+V_SYNC+V_BP. Default 525.
- Divider `div`:
  - Counts 0..CLK_DIV-1 while `en`=1.
  - `pix_tick` = (`div`==CLK_DIV-1) and `en`. With CLK_DIV=1, `pix_tick` = `en`.
- On each `pix_tick`, the output stage registers values derived from the current (`h_cnt`,`v_cnt`):
  - `hsync` = HS_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - `vsync` follows the same rule using the V parameters and `v_cnt`.
  - `de` = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - `rgb` = `de` ? `pix_rgb_in` : 0.
  - `line_start` = (h_cnt==0). It is held for exactly one clk, then cleared.
  - `frame_start` = (h_cnt==0 and v_cnt==0). It is held for exactly one clk, then cleared.
- Counter advance, in the same `pix_tick` cycle:
  - `h_cnt` increments and wraps to 0 at H_TOTAL-1.
  - On that wrap, `v_cnt` increments and wraps to 0 at V_TOTAL-1.
  - On the `v_cnt` wrap, `frame_cnt` increments modulo 2^FCNT_W.
- `pix_x`/`pix_y` are the counter registers themselves. The pixel source has CLK_DIV clk cycles, minus its own latency, to present `pix_rgb_in`.
- `en`=0:
  - `div`, `h_cnt` and `v_cnt` freeze.
  - `hsync`/`vsync` are forced to their deasserted levels, and `rgb`=0, `de`=0.
  - Strobes are 0 and `frame_cnt` holds.
  - Re-asserting `en` resumes from the frozen position.
- Reset values (`rst`=1, overrides `en`):
  - `div`=0, `h_cnt`=0, `v_cnt`=0, `frame_cnt`=0.
  - `hsync`=~HS_POL, `vsync`=~VS_POL.
  - `rgb`=0, `de`=0, `line_start`=0, `frame_start`=0.
- Reset mid-frame: the next clk after release starts a full clean frame. The first `pix_tick` follows CLK_DIV cycles later and outputs pixel (0,0) with `frame_start`=1.

## Timing
- Output latency: every output is exactly one `pix_tick` behind the coordinate it describes, and all outputs change on the same clk edge.
- No combinational path exists from `pix_rgb_in` to any output.
- Horizontal timing, in pixel ticks:
  - Line period is H_TOTAL×CLK_DIV clk. Default 3200.
  - `hsync` is asserted for H_SYNC ticks, starting at the tick of h_cnt=656.
- Vertical timing:
  - Frame period is H_TOTAL×V_TOTAL×CLK_DIV clk. Default 1,680,000.
  - `vsync` is asserted for V_SYNC full lines, from v_cnt=490 to 491. It changes on the same edge as the `hsync`-bearing line boundary (h_cnt=0).
- `frame_cnt` increments on the tick that registers the last pixel (H_TOTAL-1, V_TOTAL-1). The next tick carries `frame_start`.

## Test plan
- Reset release, defaults, `en`=1:
  - First `pix_tick` at clk 4 after release.
  - `frame_start`=`line_start`=1 one clk later, with `de`=1 and `rgb`=`pix_rgb_in`.
  - Outputs equal reset values until then.
- Horizontal sweep with `pix_rgb_in`=8'hFF:
  - `de` is high for 640 ticks per line and `rgb`=0 for the other 160.
  - `hsync` is low for exactly 96 ticks (384 clk), beginning 656 ticks after `line_start`.
  - Line period is 3200 clk.
- Full frame:
  - `vsync` is low for exactly 2 lines (6400 clk).
  - `frame_start` pulses are spaced 1,680,000 clk apart.
  - `frame_cnt` steps 0→1→2 over two frames.
- Parameter variant CLK_DIV=1, HS_POL=VS_POL=1, 8×4 active with 1/2/1 and 1/1/1 porches:
  - `pix_tick` is continuous and the syncs are active-high.
  - Frame period is 12×7=84 clk.
- `en` dropped at h_cnt=100, v_cnt=3 for 50 clk:
  - Syncs go deasserted and `rgb`=0 during the gap.
  - Resumes at h_cnt=100 with no skipped pixel, and `frame_cnt` is unchanged.
- `rst` asserted mid-frame (v_cnt=200) for 3 clk:
  - All outputs return to reset values on the next edge.
  - After release, a clean (0,0) `frame_start` follows 4 clk later.
